// File: rtl/jump_trajectory.sv
// Fixed-point ballistic jump generator: integrates height and distance once per
// physics tick from a latched launch speed, then holds the landing distance until released.
module jump_trajectory #(
  parameter int TICK_DIV = 200000,
  parameter int H_SHIFT  = 5,
  parameter int D_SHIFT  = 7
) (
  input  logic        clk_jump,
  input  logic        rst_jump,
  input  logic        i_jump_en,
  input  logic [10:0] i_jump_v_init,
  output logic [10:0] o_jump_dist,
  output logic [8:0]  o_jump_height,
  output logic        o_jump_done,
  output logic        o_busy
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FLY,
    S_DONE
  } state_t;

  state_t             state, state_nxt;
  logic [6:0]         v, v_nxt;
  logic signed [8:0]  vy, vy_nxt;
  logic [13:0]        h_acc, h_acc_nxt;
  logic [14:0]        d_acc, d_acc_nxt;
  logic [CNT_W-1:0]   tick_cnt, tick_cnt_nxt;
  logic [7:0]         n, n_nxt;
  logic [10:0]        dist_nxt;
  logic [8:0]         height_nxt;
  logic               done_nxt, busy_nxt;

  logic               tick;
  logic [6:0]         v_sat;
  logic [14:0]        h_sum;
  logic [13:0]        h_new;
  logic [14:0]        d_new;
  logic [7:0]         n_new;
  logic               last_tick;

  // Launch speeds above the physical range clamp to the maximum rather than wrap.
  assign v_sat     = (i_jump_v_init > 11'd127) ? 7'd127 : i_jump_v_init[6:0];
  assign tick      = (state == S_FLY) && (tick_cnt == CNT_W'(TICK_DIV - 1));
  // vy reaches -128 at worst; sign-extending into a modular sum keeps h_acc exact.
  assign h_sum     = {1'b0, h_acc} + {{6{vy[8]}}, vy};
  assign h_new     = h_sum[13:0];
  assign d_new     = d_acc + {8'd0, v};
  assign n_new     = n + 8'd1;
  assign last_tick = (n_new == {v, 1'b1});

  always_comb begin
    // NOTE: every signal gets a hold/default value first so no path infers a latch.
    state_nxt    = state;
    v_nxt        = v;
    vy_nxt       = vy;
    h_acc_nxt    = h_acc;
    d_acc_nxt    = d_acc;
    tick_cnt_nxt = tick_cnt;
    n_nxt        = n;
    dist_nxt     = o_jump_dist;
    height_nxt   = o_jump_height;
    done_nxt     = o_jump_done;
    busy_nxt     = o_busy;

    unique case (state)
      S_IDLE: begin
        if (i_jump_en) begin
          state_nxt    = S_FLY;
          v_nxt        = v_sat;
          vy_nxt       = $signed({2'b00, v_sat});
          h_acc_nxt    = '0;
          d_acc_nxt    = '0;
          tick_cnt_nxt = '0;
          n_nxt        = '0;
          busy_nxt     = 1'b1;
        end
      end

      S_FLY: begin
        if (!i_jump_en) begin
          // Abort: drop everything without ever signalling a landing.
          state_nxt  = S_IDLE;
          dist_nxt   = '0;
          height_nxt = '0;
          done_nxt   = 1'b0;
          busy_nxt   = 1'b0;
        end else if (tick) begin
          tick_cnt_nxt = '0;
          h_acc_nxt    = h_new;
          vy_nxt       = vy - 9'sd1;
          d_acc_nxt    = d_new;
          n_nxt        = n_new;
          height_nxt   = 9'(h_new >> H_SHIFT);
          dist_nxt     = 11'(d_new >> D_SHIFT);
          if (last_tick) begin
            state_nxt = S_DONE;
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
          end
        end else begin
          tick_cnt_nxt = tick_cnt + CNT_W'(1);
        end
      end

      S_DONE: begin
        if (!i_jump_en) begin
          state_nxt  = S_IDLE;
          dist_nxt   = '0;
          height_nxt = '0;
          done_nxt   = 1'b0;
        end
      end

      default: begin
        state_nxt  = S_IDLE;
        dist_nxt   = '0;
        height_nxt = '0;
        done_nxt   = 1'b0;
        busy_nxt   = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_jump or posedge rst_jump) begin
    if (rst_jump) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk_jump or posedge rst_jump) begin
    if (rst_jump) begin
      v             <= '0;
      vy            <= '0;
      h_acc         <= '0;
      d_acc         <= '0;
      tick_cnt      <= '0;
      n             <= '0;
      o_jump_dist   <= '0;
      o_jump_height <= '0;
      o_jump_done   <= 1'b0;
      o_busy        <= 1'b0;
    end else begin
      v             <= v_nxt;
      vy            <= vy_nxt;
      h_acc         <= h_acc_nxt;
      d_acc         <= d_acc_nxt;
      tick_cnt      <= tick_cnt_nxt;
      n             <= n_nxt;
      o_jump_dist   <= dist_nxt;
      o_jump_height <= height_nxt;
      o_jump_done   <= done_nxt;
      o_busy        <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_jump_trajectory.sv
// Directed bench for jump_trajectory with TICK_DIV=4: full, mid, zero and saturated
// jumps, the done handshake, mid-flight abort and asynchronous reset.
module tb_jump_trajectory;

  logic        clk_jump;
  logic        rst_jump;
  logic        i_jump_en;
  logic [10:0] i_jump_v_init;
  logic [10:0] o_jump_dist;
  logic [8:0]  o_jump_height;
  logic        o_jump_done;
  logic        o_busy;

  int errors = 0;
  int checks = 0;
  int since_entry;

  jump_trajectory #(
    .TICK_DIV(4),
    .H_SHIFT (5),
    .D_SHIFT (7)
  ) dut (
    .clk_jump     (clk_jump),
    .rst_jump     (rst_jump),
    .i_jump_en    (i_jump_en),
    .i_jump_v_init(i_jump_v_init),
    .o_jump_dist  (o_jump_dist),
    .o_jump_height(o_jump_height),
    .o_jump_done  (o_jump_done),
    .o_busy       (o_busy)
  );

  initial clk_jump = 1'b0;
  always #5 clk_jump = ~clk_jump;

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Advance to the falling edge that follows rising edge m after FLY entry (edge 0 is entry).
  task automatic advance_to(input int m);
    while (since_entry < m) begin
      @(negedge clk_jump);
      since_entry++;
    end
  endtask

  task automatic start_jump(input int v_init);
    i_jump_v_init = 11'(v_init);
    i_jump_en     = 1'b1;
    since_entry   = -1;
  endtask

  initial begin
    rst_jump      = 1'b1;
    i_jump_en     = 1'b0;
    i_jump_v_init = '0;
    since_entry   = 0;

    // Reset state
    repeat (3) @(negedge clk_jump);
    check("rst_dist",   int'(o_jump_dist),   0);
    check("rst_height", int'(o_jump_height), 0);
    check("rst_done",   int'(o_jump_done),   0);
    check("rst_busy",   int'(o_busy),        0);
    rst_jump = 1'b0;
    repeat (2) @(negedge clk_jump);
    check("idle_after_rst_busy", int'(o_busy), 0);

    // Full jump, v=127
    start_jump(127);
    advance_to(0);
    check("v127_busy_entry", int'(o_busy), 1);
    advance_to(3);
    check("v127_no_tick_yet_h", int'(o_jump_height), 0);
    advance_to(4);
    check("v127_tick1_h", int'(o_jump_height), 3);
    check("v127_tick1_d", int'(o_jump_dist),   0);
    advance_to(512);
    check("v127_peak_h", int'(o_jump_height), 254);
    advance_to(516);
    check("v127_tick129_h", int'(o_jump_height), 253);
    advance_to(1019);
    check("v127_pre_done", int'(o_jump_done), 0);
    check("v127_pre_dist", int'(o_jump_dist), 252);
    check("v127_pre_busy", int'(o_busy),      1);
    advance_to(1020);
    check("v127_done",   int'(o_jump_done),   1);
    check("v127_dist",   int'(o_jump_dist),   253);
    check("v127_height", int'(o_jump_height), 0);
    check("v127_busy",   int'(o_busy),        0);

    // Handshake: hold en for 10 cycles, then release
    advance_to(1030);
    check("hold_done", int'(o_jump_done), 1);
    check("hold_dist", int'(o_jump_dist), 253);
    i_jump_en = 1'b0;
    advance_to(1031);
    check("release_done",   int'(o_jump_done),   0);
    check("release_dist",   int'(o_jump_dist),   0);
    check("release_height", int'(o_jump_height), 0);
    check("release_busy",   int'(o_busy),        0);
    repeat (2) @(negedge clk_jump);

    // Mid jump, v=64; launch speed input changes after entry must be ignored
    start_jump(64);
    advance_to(0);
    i_jump_v_init = 11'd5;
    advance_to(260);
    check("v64_peak_h", int'(o_jump_height), 65);
    advance_to(264);
    check("v64_tick66_h", int'(o_jump_height), 64);
    advance_to(515);
    check("v64_pre_done", int'(o_jump_done), 0);
    advance_to(516);
    check("v64_done", int'(o_jump_done), 1);
    check("v64_dist", int'(o_jump_dist), 64);
    i_jump_en = 1'b0;
    advance_to(517);
    check("v64_release_dist", int'(o_jump_dist), 0);
    repeat (2) @(negedge clk_jump);

    // Zero speed lands on the first tick
    start_jump(0);
    advance_to(3);
    check("v0_pre_done", int'(o_jump_done), 0);
    check("v0_busy",     int'(o_busy),      1);
    advance_to(4);
    check("v0_done",   int'(o_jump_done),   1);
    check("v0_dist",   int'(o_jump_dist),   0);
    check("v0_height", int'(o_jump_height), 0);
    i_jump_en = 1'b0;
    advance_to(5);
    check("v0_release_done", int'(o_jump_done), 0);
    repeat (2) @(negedge clk_jump);

    // Saturation: v=300 behaves as v=127
    start_jump(300);
    advance_to(4);
    check("v300_tick1_h", int'(o_jump_height), 3);
    advance_to(512);
    check("v300_peak_h", int'(o_jump_height), 254);
    advance_to(1019);
    check("v300_pre_done", int'(o_jump_done), 0);
    advance_to(1020);
    check("v300_done", int'(o_jump_done), 1);
    check("v300_dist", int'(o_jump_dist), 253);
    i_jump_en = 1'b0;
    advance_to(1021);
    check("v300_release_done", int'(o_jump_done), 0);
    repeat (2) @(negedge clk_jump);

    // Abort at tick 50 of v=127
    start_jump(127);
    advance_to(200);
    check("abort_tick50_h", int'(o_jump_height), 160);
    check("abort_tick50_d", int'(o_jump_dist),   49);
    i_jump_en = 1'b0;
    advance_to(201);
    check("abort_busy",   int'(o_busy),        0);
    check("abort_dist",   int'(o_jump_dist),   0);
    check("abort_height", int'(o_jump_height), 0);
    check("abort_done",   int'(o_jump_done),   0);
    advance_to(1030);
    check("abort_done_later", int'(o_jump_done), 0);
    check("abort_busy_later", int'(o_busy),      0);

    // Asynchronous reset mid-flight, then a clean jump
    start_jump(127);
    advance_to(100);
    check("prerst_tick25_h", int'(o_jump_height), 89);
    check("prerst_tick25_d", int'(o_jump_dist),   24);
    #2;
    rst_jump = 1'b1;
    #1;
    check("async_rst_busy",   int'(o_busy),        0);
    check("async_rst_dist",   int'(o_jump_dist),   0);
    check("async_rst_height", int'(o_jump_height), 0);
    i_jump_en = 1'b0;
    @(negedge clk_jump);
    rst_jump = 1'b0;
    repeat (2) @(negedge clk_jump);
    check("post_rst_idle_busy", int'(o_busy), 0);
    start_jump(64);
    advance_to(4);
    check("clean_tick1_h", int'(o_jump_height), 2);
    check("clean_tick1_d", int'(o_jump_dist),   0);
    advance_to(8);
    check("clean_tick2_h", int'(o_jump_height), 3);
    check("clean_tick2_d", int'(o_jump_dist),   1);
    i_jump_en = 1'b0;
    advance_to(9);
    check("clean_abort_busy", int'(o_busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
